lab_1_moore: RTL and testbench

LAB_1_MOORE -- requirements
Module: lab_1_moore

---
 rtl/lab_1_moore_pkg.sv | 24 ++
 rtl/lab_1_moore_if.sv | 12 +
 rtl/lab_1_moore.sv | 44 ++++
 tb/tb_lab_1_moore.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/lab_1_moore_pkg.sv
// rtl/lab_1_moore_pkg.sv - shared state encodings for the lab_1_moore edge detector
`timescale 1ns/1ps
package lab_1_moore_pkg;

  // State encodings shared by the RTL and the bench
  localparam logic [1:0] ST_ZERO = 2'b00;  // level low, idle
  localparam logic [1:0] ST_EDG  = 2'b01;  // rising edge just detected
  localparam logic [1:0] ST_ONE  = 2'b10;  // level held high
  localparam logic [1:0] ST_BAD  = 2'b11;  // unused encoding, recovers to ST_ZERO

  // Symbolic view of the encodings for readable debug
  typedef enum logic [1:0] {
    S_ZERO = ST_ZERO,
    S_EDG  = ST_EDG,
    S_ONE  = ST_ONE,
    S_BAD  = ST_BAD
  } state_e;

  // tick is a pure decode of the state register
  function automatic logic tick_of(input logic [1:0] st, input logic [1:0] edg);
    return (st == edg);
  endfunction

endpackage

// File: rtl/lab_1_moore_if.sv
// rtl/lab_1_moore_if.sv - level/tick signal bundle for the lab_1_moore edge detector
`timescale 1ns/1ps
interface lab_1_moore_if;

  logic level;
  logic tick;

  // master drives the level and observes tick; slave is the detector side
  modport master (output level, input tick);
  modport slave  (input level, output tick);

endinterface

// File: rtl/lab_1_moore.sv
// rtl/lab_1_moore.sv - Moore FSM rising-edge detector producing a one-cycle tick
`timescale 1ns/1ps
module lab_1_moore
  import lab_1_moore_pkg::*;
#(
  parameter logic [1:0] ZERO = ST_ZERO,
  parameter logic [1:0] EDG  = ST_EDG,
  parameter logic [1:0] ONE  = ST_ONE
) (
  input  logic level,
  input  logic clk,
  output logic tick,
  input  logic rst
);

  logic [1:0] state_q;
  logic [1:0] state_d;

  // State register; reset wins over any transition
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ZERO;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state from the sampled level; tick decoded from the register only
  always_comb begin
    state_d = ZERO;
    tick    = tick_of(state_q, EDG);
    if (state_q == ZERO) begin
      state_d = level ? EDG : ZERO;
    end else if (state_q == EDG) begin
      state_d = level ? ONE : ZERO;
    end else if (state_q == ONE) begin
      state_d = level ? ONE : ZERO;
    end else begin
      // Unused encoding falls back to idle regardless of level
      state_d = ZERO;
    end
  end

endmodule

// File: tb/tb_lab_1_moore.sv
// tb/tb_lab_1_moore.sv - self-checking bench for lab_1_moore with a sample-history reference model
`timescale 1ns/1ps
module tb_lab_1_moore;
  import lab_1_moore_pkg::*;

  logic clk = 1'b1;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model: the level seen at the previous non-reset edge (0 after reset)
  logic m_prev;

  lab_1_moore_if bus ();

  lab_1_moore dut (
    .level (bus.level),
    .clk   (clk),
    .tick  (bus.tick),
    .rst   (rst)
  );

  // Rising edges at even ns
  always #1 clk = ~clk;

  // Advance one rising edge and settle half a period later
  task automatic cyc();
    @(posedge clk);
    #0.5;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.level = 1'bx;
    cyc();
    n_cmp++;
    if (bus.tick !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_tick: got %b want 0", bus.tick);
    end
    n_cmp++;
    if (dut.state_q !== ST_ZERO) begin
      n_bad++;
      $display("FAIL reset_state: got %b want %b", dut.state_q, ST_ZERO);
    end
  endtask

  task automatic test_first_edge_glitch();
    rst = 1'b0;
    bus.level = 1'b0;
    cyc();
    n_cmp++;
    if (bus.tick !== 1'b0) begin
      n_bad++;
      $display("FAIL low_sample_tick: got %b want 0", bus.tick);
    end
    bus.level = 1'b1;
    cyc();
    n_cmp++;
    if (bus.tick !== 1'b1) begin
      n_bad++;
      $display("FAIL first_rise_tick: got %b want 1", bus.tick);
    end
    // Glitch between edges must be invisible
    #0.5 bus.level = 1'b0;
    #0.2 bus.level = 1'b1;
    #0.2 bus.level = 1'b0;
    cyc();
    n_cmp++;
    if (bus.tick !== 1'b0) begin
      n_bad++;
      $display("FAIL glitch_tick: got %b want 0", bus.tick);
    end
    n_cmp++;
    if (dut.state_q !== ST_ZERO) begin
      n_bad++;
      $display("FAIL glitch_state: got %b want %b", dut.state_q, ST_ZERO);
    end
  endtask

  task automatic test_held_high();
    int ticks = 0;
    bus.level = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (bus.tick === 1'b1) ticks++;
      n_cmp++;
      if (dut.state_q !== ((i == 0) ? ST_EDG : ST_ONE)) begin
        n_bad++;
        $display("FAIL held_state[%0d]: got %b want %b", i, dut.state_q,
                 (i == 0) ? ST_EDG : ST_ONE);
      end
    end
    n_cmp++;
    if (ticks != 1) begin
      n_bad++;
      $display("FAIL held_tick_count: got %0d want 1", ticks);
    end
    bus.level = 1'b0;
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [3:0] pat;
    pat = 4'b0101;  // applied LSB first: 1,0,1,0
    for (int i = 0; i < 4; i++) begin
      bus.level = pat[i];
      cyc();
      n_cmp++;
      if (bus.tick !== pat[i]) begin
        n_bad++;
        $display("FAIL b2b_tick[%0d]: got %b want %b", i, bus.tick, pat[i]);
      end
    end
  endtask

  task automatic test_illegal_state();
    bus.level = 1'b1;
    force dut.state_q = ST_BAD;
    #0.1;
    n_cmp++;
    if (bus.tick !== 1'b0) begin
      n_bad++;
      $display("FAIL bad_state_tick: got %b want 0", bus.tick);
    end
    n_cmp++;
    if (dut.state_d !== ST_ZERO) begin
      n_bad++;
      $display("FAIL bad_state_next: got %b want %b", dut.state_d, ST_ZERO);
    end
    bus.level = 1'b0;
    #0.1;
    release dut.state_q;
    cyc();
    n_cmp++;
    if (dut.state_q !== ST_ZERO || bus.tick !== 1'b0) begin
      n_bad++;
      $display("FAIL bad_state_recover: got state %b tick %b want %b tick 0",
               dut.state_q, bus.tick, ST_ZERO);
    end
  endtask

  task automatic test_reset_mid_high();
    bus.level = 1'b1;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    n_cmp++;
    if (dut.state_q !== ST_ZERO || bus.tick !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: got state %b tick %b want %b tick 0",
               dut.state_q, bus.tick, ST_ZERO);
    end
    rst = 1'b0;
    cyc();
    n_cmp++;
    if (bus.tick !== 1'b1) begin
      n_bad++;
      $display("FAIL post_reset_tick: got %b want 1", bus.tick);
    end
    cyc();
    n_cmp++;
    if (bus.tick !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_single: got %b want 0", bus.tick);
    end
  endtask

  task automatic test_random();
    logic exp_tick;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    m_prev = 1'b0;
    for (int i = 0; i < 300; i++) begin
      bus.level = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 15) == 0);
      cyc();
      if (rst) begin
        exp_tick = 1'b0;
        m_prev = 1'b0;
      end else begin
        exp_tick = bus.level & ~m_prev;
        m_prev = bus.level;
      end
      n_cmp++;
      if (bus.tick !== exp_tick) begin
        n_bad++;
        $display("FAIL random_tick[%0d]: got %b want %b", i, bus.tick, exp_tick);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_edge_glitch();
    test_held_high();
    test_back_to_back();
    test_illegal_state();
    test_reset_mid_high();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
